// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: instruction codes, controller states,
// status codes and the memory-wait limit.
package seq_ctrl_pkg;

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] IRrmovq = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;

  localparam int unsigned WaitLimit = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StPcUpd,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    StatAok = 3'd1,
    StatHlt = 3'd2,
    StatAdr = 3'd3,
    StatIns = 3'd4
  } stat_e;

  // Instructions that need a data-memory access after execute.
  function automatic logic is_mem_icode(input logic [3:0] icode);
    logic res;
    case (icode)
      IRmmovq, IMrmovq, ICall, IRet, IPushq, IPopq: res = 1'b1;
      IHalt, INop, IRrmovq, IIrmovq, IOpq, IJxx:    res = 1'b0;
      default:                                      res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of a memory handshake; expired_o flags the last permitted wait cycle.
module mem_wait_timer
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned Limit = WaitLimit
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit);

  logic [CntW-1:0] count_q, count_d;

  assign expired_o = (count_q == CntW'(Limit - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: walks fetch/decode/execute/memory/writeback/PC-update
// and emits one-cycle stage strobes, with halt status and a retired-instruction count.
module seq_ctrl
  import seq_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  output logic        dmem_req_o,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  output logic        f_en_o,
  output logic        d_en_o,
  output logic        e_en_o,
  output logic        m_en_o,
  output logic        w_en_o,
  output logic        pc_en_o,
  output logic [2:0]  stat_o,
  output logic        busy_o,
  output logic [31:0] instr_cnt_o
);

  state_e      state_q, state_d;
  stat_e       stat_q, stat_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  icode_q, icode_d;
  logic        wait_expired;

  // Timer restarts on every state change, so each FETCH/MEM visit gets a fresh budget.
  mem_wait_timer #(
    .Limit(WaitLimit)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (state_d != state_q),
    .en_i     ((state_q == StFetch) || (state_q == StMem)),
    .expired_o(wait_expired)
  );

  always_comb begin
    state_d    = state_q;
    stat_d     = stat_q;
    cnt_d      = cnt_q;
    icode_d    = icode_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    f_en_o     = 1'b0;
    d_en_o     = 1'b0;
    e_en_o     = 1'b0;
    m_en_o     = 1'b0;
    w_en_o     = 1'b0;
    pc_en_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          f_en_o  = 1'b1;
          icode_d = icode_i;
          if (imem_err_i) begin
            state_d = StHalt;
            stat_d  = StatAdr;
          end else if (icode_i > IPopq) begin
            state_d = StHalt;
            stat_d  = StatIns;
          end else if (icode_i == IHalt) begin
            state_d = StHalt;
            stat_d  = StatHlt;
          end else begin
            state_d = StDecode;
          end
        end else if (wait_expired) begin
          state_d = StHalt;
          stat_d  = StatAdr;
        end
      end
      StDecode: begin
        d_en_o  = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        e_en_o  = 1'b1;
        state_d = is_mem_icode(icode_q) ? StMem : StWb;
      end
      StMem: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          m_en_o = 1'b1;
          if (dmem_err_i) begin
            state_d = StHalt;
            stat_d  = StatAdr;
          end else begin
            state_d = StWb;
          end
        end else if (wait_expired) begin
          state_d = StHalt;
          stat_d  = StatAdr;
        end
      end
      StWb: begin
        w_en_o  = 1'b1;
        state_d = StPcUpd;
      end
      StPcUpd: begin
        pc_en_o = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        state_d = StFetch;
      end
      StHalt: begin
        if (start_i) begin
          state_d = StFetch;
          stat_d  = StatAok;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      stat_q  <= StatAok;
      cnt_q   <= '0;
      icode_q <= IHalt;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
    end
  end

  assign stat_o      = stat_q;
  assign busy_o      = !((state_q == StIdle) || (state_q == StHalt));
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: a vector table of single instructions with hand-computed
// strobe traces, plus hand sequences for reset, idle acks and asynchronous reset mid-access.
module tb_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [3:0]  icode_i;
  logic        imem_req_o, imem_ack_i, imem_err_i;
  logic        dmem_req_o, dmem_ack_i, dmem_err_i;
  logic        f_en_o, d_en_o, e_en_o, m_en_o, w_en_o, pc_en_o;
  logic [2:0]  stat_o;
  logic        busy_o;
  logic [31:0] instr_cnt_o;

  seq_ctrl dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .icode_i    (icode_i),
    .imem_req_o (imem_req_o),
    .imem_ack_i (imem_ack_i),
    .imem_err_i (imem_err_i),
    .dmem_req_o (dmem_req_o),
    .dmem_ack_i (dmem_ack_i),
    .dmem_err_i (dmem_err_i),
    .f_en_o     (f_en_o),
    .d_en_o     (d_en_o),
    .e_en_o     (e_en_o),
    .m_en_o     (m_en_o),
    .w_en_o     (w_en_o),
    .pc_en_o    (pc_en_o),
    .stat_o     (stat_o),
    .busy_o     (busy_o),
    .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // fdly/mdly: wait cycles before ack (16 = never accepted). seq: 3-bit stage code per cycle
  // (1=f 2=d 3=e 4=m 5=w 6=pc 0=none), oldest cycle in the most significant digit.
  typedef struct {
    logic [3:0]  icode;
    bit          ierr;
    bit          derr;
    int          fdly;
    int          mdly;
    bit          stray;
    bit          hold_start;
    int          cyc;
    int          men;
    int          dreq;
    int          pcen;
    logic [2:0]  stat;
    bit          busy;
    logic [63:0] seq;
  } vec_t;

  localparam int NumVecs = 15;
  vec_t vecs[NumVecs];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start_i    = 1'b0;
    icode_i    = 4'h0;
    imem_ack_i = 1'b0;
    imem_err_i = 1'b0;
    dmem_ack_i = 1'b0;
    dmem_err_i = 1'b0;
  endtask

  // Leaves the DUT freshly in FETCH, restarting it from IDLE/HALT if needed.
  task automatic ensure_fetch();
    if (!busy_o) begin
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      exp_cnt = 0;
      check("restart_stat", 64'(stat_o), 64'd1);
      check("restart_cnt", 64'(instr_cnt_o), 64'd0);
      check("restart_ireq", 64'(imem_req_o), 64'd1);
    end
  endtask

  task automatic run_vec(input vec_t v, output int cyc, output int men, output int dreq,
                         output int pcen, output int multi, output logic [63:0] seq);
    int  fw;
    int  mw;
    bit  done;
    logic [2:0] code;
    fw = 0; mw = 0; done = 1'b0;
    cyc = 0; men = 0; dreq = 0; pcen = 0; multi = 0; seq = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      imem_ack_i = (imem_req_o && fw == v.fdly) || (v.stray && !imem_req_o);
      imem_err_i = imem_req_o ? (fw == v.fdly && v.ierr) : v.stray;
      icode_i    = imem_req_o ? v.icode : 4'h0;
      dmem_ack_i = (dmem_req_o && mw == v.mdly) || (v.stray && !dmem_req_o);
      dmem_err_i = dmem_req_o ? (mw == v.mdly && v.derr) : v.stray;
      start_i    = v.hold_start;
      #1;
      cyc++;
      if (m_en_o) men++;
      if (dmem_req_o) dreq++;
      if (pc_en_o) pcen++;
      if ($countones({f_en_o, d_en_o, e_en_o, m_en_o, w_en_o, pc_en_o}) > 1) multi++;
      code = f_en_o ? 3'd1 : d_en_o ? 3'd2 : e_en_o ? 3'd3 : m_en_o ? 3'd4 :
             w_en_o ? 3'd5 : pc_en_o ? 3'd6 : 3'd0;
      seq = {seq[60:0], code};
      if (imem_req_o) fw++;
      if (dmem_req_o) mw++;
      if (pc_en_o) done = 1'b1;
      @(posedge clk_i);
      #1;
      if (!busy_o) done = 1'b1;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, men, dreq, pcen, multi;
    logic [63:0] seq;
    //                icode ierr derr fdly mdly stray hold cyc men dreq pc stat busy seq
    vecs[0]  = '{4'h3, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 5,  0, 0,  1, 3'd1, 1'b1, 64'o12356};
    vecs[1]  = '{4'h5, 1'b0, 1'b0, 0,  3,  1'b0, 1'b0, 9,  1, 4,  1, 3'd1, 1'b1,
                 64'o123000456};
    vecs[2]  = '{4'h4, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 6,  1, 1,  1, 3'd1, 1'b1, 64'o123456};
    vecs[3]  = '{4'h6, 1'b0, 1'b0, 2,  0,  1'b0, 1'b0, 7,  0, 0,  1, 3'd1, 1'b1, 64'o12356};
    vecs[4]  = '{4'h0, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 1,  0, 0,  0, 3'd2, 1'b0, 64'o1};
    vecs[5]  = '{4'hC, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 1,  0, 0,  0, 3'd4, 1'b0, 64'o1};
    vecs[6]  = '{4'h3, 1'b1, 1'b0, 0,  0,  1'b0, 1'b0, 1,  0, 0,  0, 3'd3, 1'b0, 64'o1};
    vecs[7]  = '{4'h9, 1'b0, 1'b1, 0,  1,  1'b0, 1'b0, 5,  1, 2,  0, 3'd3, 1'b0, 64'o12304};
    vecs[8]  = '{4'h8, 1'b0, 1'b0, 0,  16, 1'b0, 1'b0, 19, 0, 16, 0, 3'd3, 1'b0,
                 64'o1230000000000000000};
    vecs[9]  = '{4'hA, 1'b0, 1'b0, 0,  15, 1'b0, 1'b0, 21, 1, 16, 1, 3'd1, 1'b1,
                 64'o123000000000000000456};
    vecs[10] = '{4'h1, 1'b0, 1'b0, 16, 0,  1'b0, 1'b0, 16, 0, 0,  0, 3'd3, 1'b0, 64'o0};
    vecs[11] = '{4'h2, 1'b0, 1'b0, 15, 0,  1'b0, 1'b0, 20, 0, 0,  1, 3'd1, 1'b1, 64'o12356};
    vecs[12] = '{4'hB, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 6,  1, 1,  1, 3'd1, 1'b1, 64'o123456};
    vecs[13] = '{4'hF, 1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 1,  0, 0,  0, 3'd4, 1'b0, 64'o1};
    vecs[14] = '{4'h6, 1'b0, 1'b0, 0,  0,  1'b1, 1'b1, 5,  0, 0,  1, 3'd1, 1'b1, 64'o12356};

    rst_n_i = 1'b0;
    idle_inputs();
    #12;
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_stat", 64'(stat_o), 64'd1);
    check("reset_cnt", 64'(instr_cnt_o), 64'd0);
    check("reset_reqs", 64'({imem_req_o, dmem_req_o}), 64'd0);
    check("reset_ens", 64'({f_en_o, d_en_o, e_en_o, m_en_o, w_en_o, pc_en_o}), 64'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Fetch ack while IDLE must not start anything.
    imem_ack_i = 1'b1;
    icode_i    = 4'h3;
    #1;
    check("idle_ack_fen", 64'(f_en_o), 64'd0);
    @(posedge clk_i);
    #1;
    idle_inputs();
    check("idle_ack_busy", 64'(busy_o), 64'd0);

    for (int i = 0; i < NumVecs; i++) begin
      ensure_fetch();
      run_vec(vecs[i], cyc, men, dreq, pcen, multi, seq);
      if (vecs[i].pcen == 1) exp_cnt++;
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_seq", i), seq, vecs[i].seq);
      check($sformatf("v%0d_men", i), 64'(men), 64'(vecs[i].men));
      check($sformatf("v%0d_dreq", i), 64'(dreq), 64'(vecs[i].dreq));
      check($sformatf("v%0d_pcen", i), 64'(pcen), 64'(vecs[i].pcen));
      check($sformatf("v%0d_onehot", i), 64'(multi), 64'd0);
      check($sformatf("v%0d_stat", i), 64'(stat_o), 64'(vecs[i].stat));
      check($sformatf("v%0d_busy", i), 64'(busy_o), 64'(vecs[i].busy));
      check($sformatf("v%0d_cnt", i), 64'(instr_cnt_o), 64'(exp_cnt));
    end

    // Asynchronous reset in the middle of a data access.
    ensure_fetch();
    icode_i    = 4'h5;
    imem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    idle_inputs();
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    check("midmem_dreq", 64'(dmem_req_o), 64'd1);
    #2;
    rst_n_i    = 1'b0;
    dmem_ack_i = 1'b1;
    #1;
    check("rst_dreq", 64'(dmem_req_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_stat", 64'(stat_o), 64'd1);
    check("rst_cnt", 64'(instr_cnt_o), 64'd0);
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    check("post_rst_busy", 64'(busy_o), 64'd0);
    check("post_rst_dreq", 64'(dmem_req_o), 64'd0);
    check("post_rst_men", 64'(m_en_o), 64'd0);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start_i  input  1  begin execution from IDLE or HALT.
REQ-004 SHALL have port icode_i  input  4  instruction code of fetched instruction, valid when imem_ack_i=1.
REQ-005 SHALL have ports imem_req_o output 1 / imem_ack_i input 1 / imem_err_i input 1  instruction-fetch handshake and error.
REQ-006 SHALL have ports dmem_req_o output 1 / dmem_ack_i input 1 / dmem_err_i input 1  data-memory handshake and error.
REQ-007 SHALL have enable outputs f_en_o, d_en_o, e_en_o, m_en_o, w_en_o, pc_en_o  output  1 each  one-cycle stage strobes.
REQ-008 SHALL have port stat_o  output  3  status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-009 SHALL have ports busy_o output 1 (state not IDLE/HALT) and instr_cnt_o output 32 (retired instructions).

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT.
REQ-011 IDLE SHALL go to FETCH on start_i=1; start_i in any other non-HALT state SHALL be ignored.
REQ-012 FETCH SHALL hold imem_req_o=1 until imem_ack_i; on ack, f_en_o=1 that cycle and icode_i latched.
REQ-013 On fetch ack: imem_err_i=1 -> HALT, stat ADR; icode>0xB -> HALT, stat INS; icode=0 (halt) -> HALT, stat HLT; else -> DECODE.
REQ-014 DECODE, EXEC, WB, PCUPD SHALL each last exactly one cycle asserting d_en_o, e_en_o, w_en_o, pc_en_o respectively.
REQ-015 EXEC SHALL go to MEM for icodes 4,5,8,9,A,B (rmmovq, mrmovq, call, ret, pushq, popq); otherwise to WB.
REQ-016 MEM SHALL hold dmem_req_o=1 until dmem_ack_i; m_en_o=1 in the ack cycle; dmem_err_i=1 at ack -> HALT, stat ADR; else -> WB.
REQ-017 Latency from FETCH entry to PCUPD completion with same-cycle ack: 5 cycles non-memory, 6 cycles memory.
REQ-018 PCUPD SHALL increment instr_cnt_o (wraps 0xFFFFFFFF->0) and return to FETCH.
REQ-019 Wait timer SHALL count cycles in FETCH/MEM with req high; ack in wait cycle 16 is accepted; no ack after 16 cycles -> HALT, stat ADR; timer clears on each state entry.
REQ-020 Acks outside FETCH/MEM SHALL be ignored; req outputs SHALL be 0 in all other states.
REQ-021 HALT SHALL hold all enables and reqs at 0 and stat_o sticky; start_i in HALT -> FETCH, stat_o=AOK, instr_cnt_o=0.
REQ-022 start_i in IDLE SHALL clear instr_cnt_o to 0.
REQ-023 At most one enable output SHALL be high in any cycle.

Reset
REQ-024 rst_n_i=0 SHALL immediately force state IDLE, all enables/reqs 0, stat_o=AOK (1), instr_cnt_o=0, timer 0, regardless of clock.
REQ-025 Reset mid-handshake SHALL drop req the same instant; a pending ack after release SHALL be ignored.

Structure
REQ-026 State encodings, stat codes and wait limit (16) SHALL live in shared define.v alongside existing icode macros (IHALT, IRMMOVQ, ...).
REQ-027 Timer SHALL be a sub-module mem_wait_timer (clear, enable, expired output).

Verification
REQ-028 Reset, start_i, irmovq (icode 3) with immediate ack -> f,d,e,w,pc strobes on 5 consecutive cycles, instr_cnt_o=1.
REQ-029 mrmovq (icode 5), dmem_ack_i delayed 3 cycles -> dmem_req_o high 4 cycles, m_en_o once, 9 cycles total, stat AOK.
REQ-030 Fetch icode 0 -> HALT, stat_o=2, busy_o=0; start_i -> FETCH, stat_o=1, instr_cnt_o=0.
REQ-031 Fetch icode 0xC -> stat_o=4; imem_err_i with ack -> stat_o=3.
REQ-032 dmem_ack_i never asserted -> HALT, stat_o=3 after 16 MEM cycles; ack on cycle 16 in separate run -> WB.
REQ-033 rst_n_i low mid-MEM between clock edges -> dmem_req_o=0, state IDLE immediately; post-release ack ignored.
